// File: rtl/e_mdu_if.sv
// ---------------------------------------------------------------------------
// e_mdu_if
// Purpose : Bundles the E-stage multiply/divide unit handshake and data bus.
// Signals :
//    start  - one-cycle launch pulse for mult/multu/div/divu
//    mdu_op - 4-bit operation code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//             5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none)
//    a, b   - forwarded rs / rt operands
//    busy   - operation in flight
//    hi, lo - architectural HI / LO registers
//    rd     - move-from read data (hi for mfhi, lo for mflo, else 0)
// Modports: master drives the request side, slave is the MDU itself.
// ---------------------------------------------------------------------------
interface e_mdu_if;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd;

   modport master (
      output start, mdu_op, a, b,
      input  busy, hi, lo, rd
   );

   modport slave (
      input  start, mdu_op, a, b,
      output busy, hi, lo, rd
   );
endinterface

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu
// Purpose : MIPS-style E-stage multiply/divide unit. The 64-bit result is
//           computed in the launch cycle and parked in pending_hi/pending_lo;
//           it becomes architecturally visible in HI/LO only after a fixed
//           busy period, mimicking a multi-cycle iterative unit.
// Params  : MULT_CYCLES - busy period for mult/multu
//           DIV_CYCLES  - busy period for div/divu
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-high
//           bus   - e_mdu_if slave (start, mdu_op, a, b, busy, hi, lo, rd)
// ---------------------------------------------------------------------------
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic   clk,
   input  logic   reset,
   e_mdu_if.slave bus
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pending_hi_q, pending_hi_d;
   logic [31:0] pending_lo_q, pending_lo_d;

   logic        is_arith;
   logic        b_zero;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] quot_mag;
   logic [31:0] rem_mag;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic [31:0] rd_val;

   // Launch-cycle datapath. Signed division works on magnitudes so that the
   // 0x80000000 / -1 case never needs a signed divide that cannot represent
   // its result; the magnitude path naturally yields lo=0x80000000, hi=0.
   // Divide by zero reloads the current HI/LO as the "result", which leaves
   // them unchanged at completion (mthi/mtlo cannot land while busy).
   always_comb begin
      is_arith = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                 (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
      b_zero   = (bus.b == 32'd0);

      prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
      prod_u = {32'd0, bus.a} * {32'd0, bus.b};

      abs_a    = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
      abs_b    = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
      quot_mag = b_zero ? 32'd0 : (abs_a / abs_b);
      rem_mag  = b_zero ? 32'd0 : (abs_a % abs_b);
      quot_s   = (bus.a[31] ^ bus.b[31]) ? (~quot_mag + 32'd1) : quot_mag;
      rem_s    = bus.a[31] ? (~rem_mag + 32'd1) : rem_mag;

      quot_u = b_zero ? 32'd0 : (bus.a / bus.b);
      rem_u  = b_zero ? 32'd0 : (bus.a % bus.b);

      res_hi = hi_q;
      res_lo = lo_q;
      case (bus.mdu_op)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            if (!b_zero) begin
               res_hi = rem_s;
               res_lo = quot_s;
            end
         end
         OP_DIVU: begin
            if (!b_zero) begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: begin
         end
      endcase
   end

   // Next-state logic. Idle accepts a start or an mt write (mt only without
   // start); busy counts down and commits the pending result when cnt hits 1.
   // Anything presented while busy is dropped rather than queued.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      pending_hi_d = pending_hi_q;
      pending_lo_d = pending_lo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && is_arith) begin
               pending_hi_d = res_hi;
               pending_lo_d = res_lo;
               state_d      = S_BUSY;
               if ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU)) begin
                  cnt_d = 4'(MULT_CYCLES);
               end else begin
                  cnt_d = 4'(DIV_CYCLES);
               end
            end else if (!bus.start && (bus.mdu_op == OP_MTHI)) begin
               hi_d = bus.a;
            end else if (!bus.start && (bus.mdu_op == OP_MTLO)) begin
               lo_d = bus.a;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               hi_d    = pending_hi_q;
               lo_d    = pending_lo_q;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; synchronous reset wins over every other update and
   // discards any pending result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         pending_hi_q <= 32'd0;
         pending_lo_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         pending_hi_q <= pending_hi_d;
         pending_lo_q <= pending_lo_d;
      end
   end

   // Move-from read port: plain mux of the architectural registers, so
   // mfhi/mflo during busy see the old values.
   always_comb begin
      rd_val = 32'd0;
      case (bus.mdu_op)
         OP_MFHI: rd_val = hi_q;
         OP_MFLO: rd_val = lo_q;
         default: rd_val = 32'd0;
      endcase
   end

   assign bus.busy = (state_q == S_BUSY);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.rd   = rd_val;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu
// Purpose : Self-checking bench for e_mdu. A behavioural model (64-bit
//           arithmetic plus a remaining-cycles counter) predicts busy, hi,
//           lo and rd after every clock edge; a vector table covers the
//           key arithmetic cases, hand sequences cover the multi-cycle
//           corners, and a random phase stresses everything together.
// ---------------------------------------------------------------------------
module tb_e_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic clk = 1'b0;
   logic reset;

   e_mdu_if bus ();

   e_mdu #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Reference model state
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [31:0] m_pend_hi;
   logic [31:0] m_pend_lo;
   int          m_remaining;
   bit          m_skip;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Arithmetic reference: plain 64-bit math on sign/zero-extended operands.
   function automatic void modelResult(input logic [3:0] op, input logic [31:0] x,
                                       input logic [31:0] y, output logic [31:0] rh,
                                       output logic [31:0] rl, output bit skip);
      longint          sx, sy, sp, sq, sr;
      longint unsigned ux, uy, up;
      sx   = $signed({{32{x[31]}}, x});
      sy   = $signed({{32{y[31]}}, y});
      ux   = {32'd0, x};
      uy   = {32'd0, y};
      rh   = 32'd0;
      rl   = 32'd0;
      skip = 1'b0;
      case (op)
         OP_MULT: begin
            sp = sx * sy;
            rh = sp[63:32];
            rl = sp[31:0];
         end
         OP_MULTU: begin
            up = ux * uy;
            rh = up[63:32];
            rl = up[31:0];
         end
         OP_DIV: begin
            if (y == 32'd0) begin
               skip = 1'b1;
            end else begin
               sq = sx / sy;
               sr = sx % sy;
               rl = sq[31:0];
               rh = sr[31:0];
            end
         end
         OP_DIVU: begin
            if (y == 32'd0) begin
               skip = 1'b1;
            end else begin
               up = ux / uy;
               rl = up[31:0];
               up = ux % uy;
               rh = up[31:0];
            end
         end
         default: skip = 1'b1;
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model across the coming edge,
   // then compare every output just after the edge.
   task automatic applyStimulus(input bit st, input logic [3:0] op, input logic [31:0] x,
                                input logic [31:0] y, input bit rst);
      logic [31:0] exp_rd;
      reset      = rst;
      bus.start  = st;
      bus.mdu_op = op;
      bus.a      = x;
      bus.b      = y;

      if (rst) begin
         m_hi        = 32'd0;
         m_lo        = 32'd0;
         m_remaining = 0;
         m_skip      = 1'b0;
      end else if (m_remaining > 0) begin
         m_remaining--;
         if (m_remaining == 0 && !m_skip) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
         end
      end else if (st && op >= OP_MULT && op <= OP_DIVU) begin
         modelResult(op, x, y, m_pend_hi, m_pend_lo, m_skip);
         m_remaining = (op <= OP_MULTU) ? MULT_N : DIV_N;
      end else if (!st && op == OP_MTHI) begin
         m_hi = x;
      end else if (!st && op == OP_MTLO) begin
         m_lo = x;
      end

      @(posedge clk);
      #1;
      exp_rd = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
      checkOutput("model_busy", 32'(bus.busy), 32'(m_remaining > 0));
      checkOutput("model_hi", bus.hi, m_hi);
      checkOutput("model_lo", bus.lo, m_lo);
      checkOutput("model_rd", bus.rd, exp_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd0;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
      vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[7] = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
      vecs[8] = '{OP_MULT,  32'hFFFF_0000, 32'h0002_0000, 32'hFFFF_FFFE, 32'h0000_0000};
      vecs[9] = '{OP_DIV,   32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, 32'hD555_5556};

      m_hi        = 32'd0;
      m_lo        = 32'd0;
      m_pend_hi   = 32'd0;
      m_pend_lo   = 32'd0;
      m_remaining = 0;
      m_skip      = 1'b0;

      // Reset state, and rd=0 for every op code while held in reset
      applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_hi", bus.hi, 32'd0);
      checkOutput("reset_lo", bus.lo, 32'd0);
      for (int op = 0; op < 16; op++) begin
         applyStimulus(1'b0, 4'(op), 32'hFFFF_FFFF, 32'd0, 1'b1);
         checkOutput("reset_rd", bus.rd, 32'd0);
      end

      // Table-driven arithmetic vectors with exact timing
      for (int v = 0; v < 10; v++) begin
         int n;
         n = (vecs[v].op <= OP_MULTU) ? MULT_N : DIV_N;
         applyStimulus(1'b1, vecs[v].op, vecs[v].a, vecs[v].b, 1'b0);
         checkOutput($sformatf("vec%0d_busy_start", v), 32'(bus.busy), 32'd1);
         idle(n - 1);
         checkOutput($sformatf("vec%0d_busy_last", v), 32'(bus.busy), 32'd1);
         idle(1);
         checkOutput($sformatf("vec%0d_busy_done", v), 32'(bus.busy), 32'd0);
         checkOutput($sformatf("vec%0d_hi", v), bus.hi, vecs[v].exp_hi);
         checkOutput($sformatf("vec%0d_lo", v), bus.lo, vecs[v].exp_lo);
      end

      // mtlo then mflo the next cycle
      applyStimulus(1'b0, OP_MTLO, 32'h1234_5678, 32'd0, 1'b0);
      applyStimulus(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
      checkOutput("mflo_rd", bus.rd, 32'h1234_5678);

      // mthi and mfhi during busy: write ignored, read sees old hi
      applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b0);
      applyStimulus(1'b0, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
      applyStimulus(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
      checkOutput("mfhi_busy_rd", bus.rd, 32'hFFFF_FFFE);
      idle(3);
      checkOutput("mthi_busy_hi", bus.hi, 32'd0);
      checkOutput("mthi_busy_lo", bus.lo, 32'd6);

      // Second start at T+2 is dropped; completion at T+5 with first result
      applyStimulus(1'b1, OP_MULT, 32'd7, 32'd6, 1'b0);
      idle(1);
      applyStimulus(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(3);
      checkOutput("restart_busy", 32'(bus.busy), 32'd0);
      checkOutput("restart_hi", bus.hi, 32'd0);
      checkOutput("restart_lo", bus.lo, 32'd42);
      idle(1);
      checkOutput("restart_lo_hold", bus.lo, 32'd42);

      // start with mthi/mtlo: neither an operation nor a write
      applyStimulus(1'b1, OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
      checkOutput("start_mthi_busy", 32'(bus.busy), 32'd0);
      checkOutput("start_mthi_hi", bus.hi, 32'd0);
      applyStimulus(1'b1, OP_MTLO, 32'hAAAA_5555, 32'd0, 1'b0);
      checkOutput("start_mtlo_lo", bus.lo, 32'd42);

      // Reset at T+3 of a div aborts it; a fresh mult then completes
      applyStimulus(1'b1, OP_DIV, 32'd100, 32'd3, 1'b0);
      idle(2);
      applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_hi", bus.hi, 32'd0);
      checkOutput("abort_lo", bus.lo, 32'd0);
      idle(DIV_N);
      checkOutput("abort_no_commit_lo", bus.lo, 32'd0);
      applyStimulus(1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
      idle(MULT_N);
      checkOutput("post_abort_lo", bus.lo, 32'd25);
      checkOutput("post_abort_busy", 32'(bus.busy), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit          st;
         bit          rst;
         logic [3:0]  op;
         st  = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 79) == 0);
         op  = 4'($urandom_range(0, 15));
         applyStimulus(st, op, pickOperand(), pickOperand(), rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
